my_mem: RTL and testbench

MY_MEM -- requirements
Module: my_mem

---
 rtl/my_mem_pkg.sv | 10 +
 rtl/parity_gen.sv | 11 +
 rtl/my_mem.sv | 97 +++++++++
 tb/tb_my_mem.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/my_mem_pkg.sv
// Shared constants and word type for the parity-protected memory.
package my_mem_pkg;

   localparam int unsigned MemAddrW = 16;
   localparam int unsigned MemDataW = 8;

   // Stored word: {parity, data}
   typedef logic [MemDataW:0] word_t;

endpackage

// File: rtl/parity_gen.sv
// Combinational odd-parity generator: output is 1 when the input has an even number of ones.
module parity_gen #(
   parameter int unsigned Width = 8
) (
   input  logic [Width-1:0] data_i,
   output logic             parity_o
);

   assign parity_o = ~^data_i;

endmodule

// File: rtl/my_mem.sv
// Single-port memory storing {odd parity, data} words with a registered read port.
// Defining MY_MEM_PARITY_CHECK_EN adds a registered parity_err flag checked on each read.
module my_mem
   import my_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = MemAddrW,
   parameter int unsigned DATA_W = MemDataW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write,
   input  logic              read,
   input  logic [DATA_W-1:0] data_in,
   input  logic [ADDR_W-1:0] address,
   output logic [DATA_W:0]   data_out
`ifdef MY_MEM_PARITY_CHECK_EN
   ,
   output logic              parity_err
`endif
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [DATA_W:0] mem_q [Depth];
   logic [DATA_W:0] data_out_q, data_out_d;
   logic [DATA_W:0] wr_word, rd_word;
   logic            wr_parity;
   logic            wr_en, rd_en;

   // Write wins over read; reset aborts either access.
   assign wr_en = write & ~rst;
   assign rd_en = read & ~write & ~rst;

   parity_gen #(
      .Width (DATA_W)
   ) u_parity_wr (
      .data_i   (data_in),
      .parity_o (wr_parity)
   );

   assign wr_word = {wr_parity, data_in};
   assign rd_word = mem_q[address];

   // Memory array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[address] <= wr_word;
      end
   end

   always_comb begin
      data_out_d = data_out_q;
      if (rd_en) begin
         data_out_d = rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out_q <= '0;
      end else begin
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;

`ifdef MY_MEM_PARITY_CHECK_EN
   logic rd_parity;
   logic parity_err_q, parity_err_d;

   parity_gen #(
      .Width (DATA_W)
   ) u_parity_rd (
      .data_i   (rd_word[DATA_W-1:0]),
      .parity_o (rd_parity)
   );

   always_comb begin
      parity_err_d = parity_err_q;
      if (rd_en) begin
         parity_err_d = (rd_word[DATA_W] != rd_parity);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_my_mem.sv
// Self-checking bench for my_mem against a queue/associative-array memory model.
// Parity-error checks run only when MY_MEM_PARITY_CHECK_EN is defined.
module tb_my_mem;
   import my_mem_pkg::*;

   localparam int unsigned AW = MemAddrW;
   localparam int unsigned DW = MemDataW;

   logic          clk;
   logic          rst;
   logic          write;
   logic          read;
   logic [DW-1:0] data_in;
   logic [AW-1:0] address;
   word_t         data_out;
`ifdef MY_MEM_PARITY_CHECK_EN
   logic          parity_err;
`endif

   int checks;
   int failures;

   word_t model_mem [int];
   word_t model_dout;

   my_mem #(
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .write      (write),
      .read       (read),
      .data_in    (data_in),
      .address    (address),
      .data_out   (data_out)
`ifdef MY_MEM_PARITY_CHECK_EN
      ,
      .parity_err (parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Odd parity: top bit set when the data holds an even count of ones.
   function automatic word_t ref_word(input logic [DW-1:0] d);
      return {(($countones(d) % 2) == 0) ? 1'b1 : 1'b0, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      write = 1'b1; read = 1'b0; address = a; data_in = d;
      tick();
      write = 1'b0;
      model_mem[int'(a)] = ref_word(d);
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      write = 1'b0; read = 1'b1; address = a;
      tick();
      read = 1'b0;
      model_dout = model_mem[int'(a)];
   endtask

   task automatic test_reset();
      rst = 1'b1; write = 1'b0; read = 1'b0; data_in = '0; address = '0;
      tick();
      tick();
      model_dout = '0;
      checks++;
      if (data_out !== 9'h000) begin
         failures++;
         $display("FAIL reset_dout got=%h exp=%h", data_out, 9'h000);
      end
`ifdef MY_MEM_PARITY_CHECK_EN
      checks++;
      if (parity_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_perr got=%b exp=0", parity_err);
      end
`endif
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      do_write(16'h1234, 8'hA5);
      checks++;
      if (data_out !== 9'h000) begin
         failures++;
         $display("FAIL basic_no_write_through got=%h exp=%h", data_out, 9'h000);
      end
      do_read(16'h1234);
      checks++;
      if (data_out !== 9'h1A5) begin
         failures++;
         $display("FAIL basic_read got=%h exp=%h", data_out, 9'h1A5);
      end
   endtask

   task automatic test_boundary();
      do_write(16'h0000, 8'h07);
      do_write(16'hFFFF, 8'h00);
      do_read(16'h0000);
      checks++;
      if (data_out !== 9'h007) begin
         failures++;
         $display("FAIL bound_lo got=%h exp=%h", data_out, 9'h007);
      end
      do_read(16'hFFFF);
      checks++;
      if (data_out !== 9'h100) begin
         failures++;
         $display("FAIL bound_hi got=%h exp=%h", data_out, 9'h100);
      end
   endtask

   task automatic test_hold_priority();
      do_read(16'h1234);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (data_out !== 9'h1A5) begin
            failures++;
            $display("FAIL idle_hold cyc=%0d got=%h exp=%h", i, data_out, 9'h1A5);
         end
      end
      write = 1'b1; read = 1'b1; address = 16'h1234; data_in = 8'hFF;
      tick();
      write = 1'b0; read = 1'b0;
      model_mem[int'(16'h1234)] = ref_word(8'hFF);
      checks++;
      if (data_out !== 9'h1A5) begin
         failures++;
         $display("FAIL wr_rd_priority got=%h exp=%h", data_out, 9'h1A5);
      end
      do_read(16'h1234);
      checks++;
      if (data_out !== 9'h1FF) begin
         failures++;
         $display("FAIL rewrite_read got=%h exp=%h", data_out, 9'h1FF);
      end
   endtask

   task automatic test_reset_retain();
      // Accesses during reset must be ignored.
      rst = 1'b1; write = 1'b1; read = 1'b1; address = 16'h1234; data_in = 8'h3C;
      tick();
      rst = 1'b0; write = 1'b0; read = 1'b0;
      model_dout = '0;
      checks++;
      if (data_out !== 9'h000) begin
         failures++;
         $display("FAIL rst_mid_dout got=%h exp=%h", data_out, 9'h000);
      end
      do_read(16'h1234);
      checks++;
      if (data_out !== model_mem[int'(16'h1234)]) begin
         failures++;
         $display("FAIL rst_retain got=%h exp=%h", data_out, model_mem[int'(16'h1234)]);
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] addrs[$];
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      for (int i = 0; i < 100; i++) begin
         a = AW'($urandom_range(0, (1 << AW) - 1));
         d = DW'($urandom_range(0, (1 << DW) - 1));
         do_write(a, d);
         addrs.push_back(a);
         checks++;
         if (data_out !== model_dout) begin
            failures++;
            $display("FAIL rand_wr_hold i=%0d got=%h exp=%h", i, data_out, model_dout);
         end
      end
      for (int i = 99; i >= 0; i--) begin
         do_read(addrs[i]);
         checks++;
         if (data_out !== model_mem[int'(addrs[i])]) begin
            failures++;
            $display("FAIL rand_rd addr=%h got=%h exp=%h", addrs[i], data_out,
                     model_mem[int'(addrs[i])]);
         end
      end
   endtask

`ifdef MY_MEM_PARITY_CHECK_EN
   task automatic test_parity();
      do_read(16'h1234);
      checks++;
      if (parity_err !== 1'b0) begin
         failures++;
         $display("FAIL perr_clean got=%b exp=0", parity_err);
      end
      dut.mem_q[16'h0010] = 9'h0A5;
      model_mem[int'(16'h0010)] = 9'h0A5;
      do_read(16'h0010);
      checks++;
      if (parity_err !== 1'b1 || data_out !== 9'h0A5) begin
         failures++;
         $display("FAIL perr_corrupt got=%b/%h exp=1/%h", parity_err, data_out, 9'h0A5);
      end
      tick();
      checks++;
      if (parity_err !== 1'b1) begin
         failures++;
         $display("FAIL perr_hold got=%b exp=1", parity_err);
      end
      do_read(16'h1234);
      checks++;
      if (parity_err !== 1'b0) begin
         failures++;
         $display("FAIL perr_clear got=%b exp=0", parity_err);
      end
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_boundary();
      test_hold_priority();
      test_reset_retain();
      test_random();
`ifdef MY_MEM_PARITY_CHECK_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
